// File: rtl/sd_crc_lanes.sv
// sd_crc_lanes: multi-lane bit-serial CRC engine for SD CMD/DAT lines.
// Each lane shifts one payload bit per accepted cycle and checks its result.
`timescale 1ns/1ps

module sd_crc_lanes #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021,
    parameter int               LANES = 4,
    parameter int               LEN   = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   bit_valid,
    input  logic [LANES-1:0]       bit_in,
    input  logic [LANES*CRC_W-1:0] crc_expect,
    output logic [LANES*CRC_W-1:0] crc,
    output logic                   crc_ready,
    output logic [LANES-1:0]       crc_match,
    output logic                   busy,
    output logic                   overrun
);

    localparam int CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LANES*CRC_W-1:0] crc_q, crc_d;
    logic [LANES*CRC_W-1:0] crc_step;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;
    logic [CRC_W-1:0]       lane_cur;
    logic                   lane_fb;

    // One LFSR step per lane; lanes are fully independent.
    always_comb begin
        crc_step = '0;
        lane_cur = '0;
        lane_fb  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_cur = crc_q[i*CRC_W +: CRC_W];
            lane_fb  = bit_in[i] ^ lane_cur[CRC_W-1];
            crc_step[i*CRC_W +: CRC_W] =
                {lane_cur[CRC_W-2:0], 1'b0} ^ (lane_fb ? POLY : '0);
        end
    end

    // Frame control: start always wins, bits outside a frame flag overrun.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        ovr_d   = ovr_q;
        if (start) begin
            state_d = S_RUN;
            cnt_d   = '0;
            crc_d   = '0;
            ovr_d   = 1'b0;
        end else if (state_q == S_RUN) begin
            if (bit_valid) begin
                crc_d = crc_step;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (bit_valid) begin
            ovr_d = 1'b1;
        end
        busy_d  = (state_d == S_RUN);
        ready_d = (state_d == S_DONE);
    end

    // State and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // Per-lane compare, only meaningful once the frame is complete.
    always_comb begin
        crc_match = '0;
        for (int i = 0; i < LANES; i++) begin
            crc_match[i] = ready_q &&
                (crc_q[i*CRC_W +: CRC_W] == crc_expect[i*CRC_W +: CRC_W]);
        end
    end

    assign crc       = crc_q;
    assign crc_ready = ready_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_sd_crc_lanes.sv
// tb_sd_crc_lanes: scoreboard bench for CMD (CRC7) and DAT (CRC16) instances.
// Expected CRCs come from polynomial long division over the payload.
`timescale 1ns/1ps

module tb_sd_crc_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        c_start, c_valid;
    logic [0:0]  c_bit;
    logic [6:0]  c_exp, c_crc;
    logic        c_ready, c_busy, c_ovr;
    logic [0:0]  c_match;

    logic        d_start, d_valid;
    logic [3:0]  d_bit;
    logic [63:0] d_exp, d_crc;
    logic        d_ready, d_busy, d_ovr;
    logic [3:0]  d_match;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0]  cmd_q[$];
    logic [63:0] dat_q[$];

    bit dpay [4][4096];

    sd_crc_lanes #(.CRC_W(7), .POLY(7'h09), .LANES(1), .LEN(40)) u_cmd (
        .clk(clk), .reset(rst_n), .start(c_start), .bit_valid(c_valid),
        .bit_in(c_bit), .crc_expect(c_exp), .crc(c_crc),
        .crc_ready(c_ready), .crc_match(c_match), .busy(c_busy),
        .overrun(c_ovr)
    );

    sd_crc_lanes #(.CRC_W(16), .POLY(16'h1021), .LANES(4), .LEN(4096)) u_dat (
        .clk(clk), .reset(rst_n), .start(d_start), .bit_valid(d_valid),
        .bit_in(d_bit), .crc_expect(d_exp), .crc(d_crc),
        .crc_ready(d_ready), .crc_match(d_match), .busy(d_busy),
        .overrun(d_ovr)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^w divided by G(x), by mod-2 long division.
    function automatic logic [15:0] ref_crc(input bit msg[$], input int w,
                                            input logic [15:0] poly);
        bit r[$];
        bit g[17];
        logic [15:0] res;
        r = msg;
        for (int k = 0; k < w; k++) r.push_back(1'b0);
        g[0] = 1'b1;
        for (int j = 1; j <= w; j++) g[j] = poly[w-j];
        for (int i = 0; i < msg.size(); i++)
            if (r[i])
                for (int j = 0; j <= w; j++) r[i+j] ^= g[j];
        res = '0;
        for (int k = 0; k < w; k++) res[w-1-k] = r[msg.size()+k];
        return res;
    endfunction

    function automatic logic [6:0] ref_cmd(input logic [39:0] p);
        bit m[$];
        logic [15:0] r;
        for (int i = 39; i >= 0; i--) m.push_back(p[i]);
        r = ref_crc(m, 7, 16'h0009);
        return r[6:0];
    endfunction

    function automatic logic [15:0] ref_lane(input int ln);
        bit m[$];
        for (int b = 0; b < 4096; b++) m.push_back(dpay[ln][b]);
        return ref_crc(m, 16, 16'h1021);
    endfunction

    // CMD frame: optional abort after stop_at bits, random bit_valid gaps.
    task automatic cmd_frame(input logic [39:0] p, input int pct,
                             input bit push, input logic [6:0] exp,
                             input int stop_at, input bit valid_on_start);
        int idx;
        if (push) cmd_q.push_back(exp);
        @(posedge clk); #1;
        c_start  = 1'b1;
        c_valid  = valid_on_start;
        c_bit[0] = valid_on_start;
        @(posedge clk); #1;
        c_start = 1'b0;
        idx = 39;
        while (idx >= 0 && (stop_at < 0 || (39 - idx) < stop_at)) begin
            c_valid  = ($urandom_range(0, 99) < pct);
            c_bit[0] = p[idx];
            if (c_valid && idx == 0) begin
                @(negedge clk);
                chk("cmd_ready_before_last", 64'(c_ready), 64'd0);
                chk("cmd_busy_before_last", 64'(c_busy), 64'd1);
            end
            @(posedge clk);
            if (c_valid) idx--;
            #1;
        end
        c_valid = 1'b0;
        if (stop_at < 0) begin
            @(negedge clk);
            chk("cmd_ready_after_last", 64'(c_ready), 64'd1);
            chk("cmd_busy_after_last", 64'(c_busy), 64'd0);
        end
    endtask

    task automatic dat_frame(input logic [63:0] exp);
        dat_q.push_back(exp);
        @(posedge clk); #1;
        d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        for (int b = 0; b < 4096; b++) begin
            d_valid = 1'b1;
            for (int i = 0; i < 4; i++) d_bit[i] = dpay[i][b];
            @(posedge clk); #1;
        end
        d_valid = 1'b0;
        @(negedge clk);
        chk("dat_ready_after_last", 64'(d_ready), 64'd1);
        chk("dat_busy_after_last", 64'(d_busy), 64'd0);
    endtask

    // CMD monitor: compare crc on every rising crc_ready.
    initial begin
        logic prev;
        logic [6:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (c_ready && !prev) begin
                if (cmd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL cmd_unexpected_ready: got crc %h", c_crc);
                end else begin
                    e = cmd_q.pop_front();
                    chk("cmd_crc", 64'(c_crc), 64'(e));
                end
            end
            prev = c_ready;
        end
    end

    // DAT monitor: compare all lanes on every rising crc_ready.
    initial begin
        logic prev;
        logic [63:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (d_ready && !prev) begin
                if (dat_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dat_unexpected_ready: got crc %h", d_crc);
                end else begin
                    e = dat_q.pop_front();
                    chk("dat_crc", d_crc, e);
                end
            end
            prev = d_ready;
        end
    end

    initial begin
        #700000;
        vectors++;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        logic [39:0] p;
        logic [6:0]  e7;
        logic [63:0] e64;
        int k;

        rst_n = 1'b0;
        c_start = 0; c_valid = 0; c_bit = '0; c_exp = '0;
        d_start = 0; d_valid = 0; d_bit = '0; d_exp = '0;
        #12;
        chk("rst_crc", 64'(c_crc), 64'd0);
        chk("rst_ready", 64'(c_ready), 64'd0);
        chk("rst_busy", 64'(c_busy), 64'd0);
        chk("rst_ovr", 64'(c_ovr), 64'd0);
        chk("rst_match_gated", 64'(c_match), 64'd0);
        chk("rst_dat_crc", d_crc, 64'd0);
        #6 rst_n = 1'b1;

        // bit_valid while IDLE
        @(posedge clk); #1 c_valid = 1'b1; c_bit = 1'b1;
        @(posedge clk); #1 c_valid = 1'b0;
        @(negedge clk);
        chk("idle_ovr_set", 64'(c_ovr), 64'd1);
        chk("idle_crc_held", 64'(c_crc), 64'd0);
        chk("idle_busy", 64'(c_busy), 64'd0);

        // CMD0, continuous valid, start clears overrun
        cmd_frame(40'h4000000000, 100, 1, 7'h4A, -1, 0);
        chk("cmd0_ovr_cleared", 64'(c_ovr), 64'd0);

        // bit_valid while DONE
        @(posedge clk); #1 c_valid = 1'b1; c_bit = 1'b1;
        repeat (3) @(posedge clk);
        #1 c_valid = 1'b0;
        @(negedge clk);
        chk("done_ovr_set", 64'(c_ovr), 64'd1);
        chk("done_crc_held", 64'(c_crc), 64'h4A);
        chk("done_ready_held", 64'(c_ready), 64'd1);
        @(posedge clk); #1 c_start = 1'b1;
        @(posedge clk); #1 c_start = 1'b0;
        @(negedge clk);
        chk("restart_ovr_clr", 64'(c_ovr), 64'd0);
        chk("restart_ready_clr", 64'(c_ready), 64'd0);
        chk("restart_busy", 64'(c_busy), 64'd1);

        // CMD17, then match checks on third payload
        cmd_frame(40'h5100000000, 100, 1, 7'h2A, -1, 0);
        cmd_frame(40'h1100000900, 100, 1, 7'h33, -1, 0);
        #1 c_exp = 7'h33;
        @(negedge clk);
        chk("match_hit", 64'(c_match), 64'd1);
        @(posedge clk); #1 c_exp = 7'h32;
        @(negedge clk);
        chk("match_miss", 64'(c_match), 64'd0);

        // Random gaps on CMD0
        cmd_frame(40'h4000000000, 50, 1, 7'h4A, -1, 0);

        // start with bit_valid in the same cycle
        cmd_frame(40'h4000000000, 100, 1, 7'h4A, -1, 1);

        // abort at bit 20, then full CMD17
        cmd_frame(40'h4000000000, 100, 0, 7'h00, 20, 0);
        @(negedge clk);
        chk("abort_busy", 64'(c_busy), 64'd1);
        cmd_frame(40'h5100000000, 100, 1, 7'h2A, -1, 0);

        // async reset mid-frame at bit 25
        cmd_frame(40'h4000000000, 100, 0, 7'h00, 25, 0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_crc", 64'(c_crc), 64'd0);
        chk("mid_rst_busy", 64'(c_busy), 64'd0);
        chk("mid_rst_ready", 64'(c_ready), 64'd0);
        chk("mid_rst_match", 64'(c_match), 64'd0);
        #3 rst_n = 1'b1;
        cmd_frame(40'h4000000000, 100, 1, 7'h4A, -1, 0);

        // random CMD payloads
        for (int n = 0; n < 6; n++) begin
            p = {8'($urandom), 32'($urandom)};
            e7 = ref_cmd(p);
            cmd_frame(p, $urandom_range(40, 100), 1, e7, -1, 0);
        end

        // DAT: all ones
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4096; b++) dpay[i][b] = 1'b1;
        d_exp = {4{16'h7FA1}};
        dat_frame({4{16'h7FA1}});
        chk("dat_match_all", 64'(d_match), 64'hF);

        // DAT: flip one bit on lane 2
        k = $urandom_range(0, 4095);
        dpay[2][k] = 1'b0;
        e64 = {4{16'h7FA1}};
        e64[32 +: 16] = ref_lane(2);
        dat_frame(e64);
        chk("dat_match_lane2", 64'(d_match), 64'hB);

        // DAT: random payload per lane
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4096; b++) dpay[i][b] = bit'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) e64[i*16 +: 16] = ref_lane(i);
        d_exp = e64 ^ 64'h0000_0000_0001_0000;
        dat_frame(e64);
        chk("dat_match_rand", 64'(d_match), 64'hD);

        repeat (3) @(negedge clk);
        chk("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        chk("dat_queue_drained", 64'(dat_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
